// File: rtl/approx_mult_pkg.sv
// Shared definitions for the approximate multiply-accumulate block:
// default widths and the result-FSM state encoding.
package approx_mult_pkg;

  localparam int ACC_W_DEF = 24;
  localparam int CNT_W_DEF = 8;

  localparam logic [1:0] ST_ACC   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

endpackage

// File: rtl/mult_8x8_2444.sv
// Combinational 8x8 unsigned approximate multiplier.
// The product is built recursively: 8x8 from four 4x4 partial products,
// each 4x4 from four 2x2 partial products. The only inexact cell is the
// 2x2 block, which returns 7 instead of 9 for 3x3 (3-bit output), so every
// 2-bit digit pair (3,3) at weight 4^(i+j) costs 2*4^(i+j) of error.
module mult_8x8_2444 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] r
);

  function automatic logic [3:0] m2(input logic [1:0] x, input logic [1:0] y);
    if (x == 2'd3 && y == 2'd3) return 4'd7;
    return {2'b00, x} * {2'b00, y};
  endfunction

  function automatic logic [7:0] m4(input logic [3:0] x, input logic [3:0] y);
    logic [7:0] ll, lh, hl, hh;
    ll = {4'b0, m2(x[1:0], y[1:0])};
    hl = {4'b0, m2(x[3:2], y[1:0])};
    lh = {4'b0, m2(x[1:0], y[3:2])};
    hh = {4'b0, m2(x[3:2], y[3:2])};
    return ll + ((hl + lh) << 2) + (hh << 4);
  endfunction

  function automatic logic [15:0] m8(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] ll, lh, hl, hh;
    ll = {8'b0, m4(x[3:0], y[3:0])};
    hl = {8'b0, m4(x[7:4], y[3:0])};
    lh = {8'b0, m4(x[3:0], y[7:4])};
    hh = {8'b0, m4(x[7:4], y[7:4])};
    return ll + ((hl + lh) << 4) + (hh << 8);
  endfunction

  // Pure combinational product
  always_comb r = m8(a, b);

endmodule

// File: rtl/approx_mac_8x8.sv
// Approximate multiply-accumulate: accepts a stream of 8x8 operand pairs,
// accumulates their approximate products (saturating), and presents the
// dot-product result with a valid/ready handshake after the last beat.
module approx_mac_8x8
  import approx_mult_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       A,
  input  logic [7:0]       B,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  logic [1:0]       state;
  logic             ready_en;
  logic [7:0]       a_p0, b_p0;
  logic             last_p0, vld_p0;
  logic [15:0]      prod;
  logic [15:0]      prod_p1;
  logic             last_p1, vld_p1;
  logic [ACC_W-1:0] acc_p2;
  logic [CNT_W-1:0] cnt_p2;
  logic             ovf_p2;
  logic             accept, hs;
  logic [ACC_W:0]   acc_next;

  // MSB of the result flags saturation; low ACC_W bits are the clamped sum.
  function automatic logic [ACC_W:0] add_sat(input logic [ACC_W-1:0] acc,
                                             input logic [15:0] p);
    logic [ACC_W:0] s;
    s = {1'b0, acc} + {{(ACC_W + 1 - 16){1'b0}}, p};
    if (s[ACC_W]) return {1'b1, {ACC_W{1'b1}}};
    return s;
  endfunction

  function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + 1'b1;
  endfunction

  assign in_ready  = ready_en && (state == ST_ACC);
  assign out_valid = (state == ST_HOLD);
  assign accept    = in_valid && in_ready;
  assign hs        = out_valid && out_ready;
  assign out_data  = acc_p2;
  assign out_count = cnt_p2;
  assign out_ovf   = ovf_p2;
  assign acc_next  = add_sat(acc_p2, prod_p1);

  // Holds in_ready low until the first clock edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // Stage 1: capture accepted operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_p0    <= '0;
      b_p0    <= '0;
      last_p0 <= 1'b0;
      vld_p0  <= 1'b0;
    end else begin
      vld_p0 <= accept;
      if (accept) begin
        a_p0    <= A;
        b_p0    <= B;
        last_p0 <= in_last;
      end
    end
  end

  mult_8x8_2444 u_mult (
    .a (a_p0),
    .b (b_p0),
    .r (prod)
  );

  // Stage 2: register the approximate product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_p1 <= '0;
      last_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      prod_p1 <= prod;
      last_p1 <= last_p0 && vld_p0;
      vld_p1  <= vld_p0;
    end
  end

  // Stage 3: saturating accumulate, cleared by the output handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p2 <= '0;
      cnt_p2 <= '0;
      ovf_p2 <= 1'b0;
    end else if (hs) begin
      acc_p2 <= '0;
      cnt_p2 <= '0;
      ovf_p2 <= 1'b0;
    end else if (vld_p1) begin
      acc_p2 <= acc_next[ACC_W-1:0];
      cnt_p2 <= inc_sat(cnt_p2);
      ovf_p2 <= ovf_p2 | acc_next[ACC_W];
    end
  end

  // Result FSM: accept beats, wait for the last product, hold the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ACC;
    end else begin
      case (state)
        ST_ACC:   if (accept && in_last)  state <= ST_DRAIN;
        ST_DRAIN: if (vld_p1 && last_p1)  state <= ST_HOLD;
        ST_HOLD:  if (out_ready)          state <= ST_ACC;
        default:                          state <= ST_ACC;
      endcase
    end
  end

endmodule
